// File: rtl/btb_sat.sv
// btb_sat: fully associative branch target buffer with saturating direction counters.
//
// Fetch side (combinational, zero latency):
//   pc_in        - fetch PC to look up
//   hit          - pc_in matches a valid entry (lowest index wins on multiple matches)
//   token        - predict taken: hit and MSB of the matching counter is set
//   next_pc_out  - matching target when token=1, otherwise pc_in
// Execute side (one resolved branch per cycle, effective at next clk edge):
//   is_req_pc      - update strobe
//   req_pc         - PC of the resolved branch
//   predict_target - resolved target
//   req_taken      - resolved direction (1 = taken)
// Control:
//   clk, reset (synchronous, active-high), flush (invalidate all entries, rr_ptr <= 0)
//
// Replacement: a taken miss fills the lowest-index invalid entry; if the table is
// full it evicts the entry at rr_ptr and advances rr_ptr.
module btb_sat #(
   parameter int ENTRIES  = 8,
   parameter int IDX_W    = 3,
   parameter int PC_W     = 32,
   parameter int CNT_W    = 2,
   parameter int CNT_INIT = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W-1:0] pc_in,
   output logic            hit,
   output logic            token,
   output logic [PC_W-1:0] next_pc_out,
   input  logic            is_req_pc,
   input  logic [PC_W-1:0] req_pc,
   input  logic [PC_W-1:0] predict_target,
   input  logic            req_taken,
   input  logic            flush
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(CNT_INIT);

   logic             valid  [ENTRIES];
   logic [PC_W-1:0]  tag    [ENTRIES];
   logic [PC_W-1:0]  target [ENTRIES];
   logic [CNT_W-1:0] cnt    [ENTRIES];
   logic [IDX_W-1:0] rr_ptr;

   logic             f_hit;
   logic [IDX_W-1:0] f_idx;
   logic             u_hit;
   logic [IDX_W-1:0] u_idx;
   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] victim;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
      return (c == '0) ? c : c - CNT_W'(1);
   endfunction

   // Associative searches. Scanning from the top down lets the lowest
   // matching index be the last one written, so it wins.
   always_comb begin
      f_hit      = 1'b0;
      f_idx      = '0;
      u_hit      = 1'b0;
      u_idx      = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid[i] && (tag[i] == pc_in)) begin
            f_hit = 1'b1;
            f_idx = IDX_W'(i);
         end
         if (valid[i] && (tag[i] == req_pc)) begin
            u_hit = 1'b1;
            u_idx = IDX_W'(i);
         end
         if (!valid[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   assign victim = free_found ? free_idx : rr_ptr;

   // Fetch outputs see pre-update state; there is no bypass from the update port.
   always_comb begin
      hit         = f_hit;
      token       = f_hit && cnt[f_idx][CNT_W-1];
      next_pc_out = pc_in;
      if (token) begin
         next_pc_out = target[f_idx];
      end
   end

   // State update: reset > flush > resolved-branch update.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i]  <= 1'b0;
            tag[i]    <= '0;
            target[i] <= '0;
            cnt[i]    <= '0;
         end
         rr_ptr <= '0;
      end else if (flush) begin
         // Only validity and the pointer are cleared; entry contents are kept.
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i] <= 1'b0;
         end
         rr_ptr <= '0;
      end else if (is_req_pc) begin
         if (u_hit) begin
            if (req_taken) begin
               cnt[u_idx]    <= sat_inc(cnt[u_idx]);
               target[u_idx] <= predict_target;
            end else begin
               cnt[u_idx] <= sat_dec(cnt[u_idx]);
            end
         end else if (req_taken) begin
            valid[victim]  <= 1'b1;
            tag[victim]    <= req_pc;
            target[victim] <= predict_target;
            cnt[victim]    <= CNT_ALLOC;
            // Pointer only moves when it actually chose the victim.
            if (!free_found) begin
               rr_ptr <= rr_ptr + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_btb_sat.sv
module tb_btb_sat;

   logic        clk;
   logic        reset;
   logic [31:0] pc_in;
   logic        hit;
   logic        token;
   logic [31:0] next_pc_out;
   logic        is_req_pc;
   logic [31:0] req_pc;
   logic [31:0] predict_target;
   logic        req_taken;
   logic        flush;

   int compared;
   int mismatched;

   btb_sat dut (
      .clk            (clk),
      .reset          (reset),
      .pc_in          (pc_in),
      .hit            (hit),
      .token          (token),
      .next_pc_out    (next_pc_out),
      .is_req_pc      (is_req_pc),
      .req_pc         (req_pc),
      .predict_target (predict_target),
      .req_taken      (req_taken),
      .flush          (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input string tag, input logic [31:0] pc,
                         input logic eh, input logic et, input logic [31:0] enpc);
      pc_in = pc;
      #1;
      chk({tag, ".hit"}, {31'b0, hit}, {31'b0, eh});
      chk({tag, ".token"}, {31'b0, token}, {31'b0, et});
      chk({tag, ".npc"}, next_pc_out, enpc);
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      is_req_pc      = 1'b1;
      req_pc         = pc;
      predict_target = tgt;
      req_taken      = tk;
      step();
      is_req_pc = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic chk_rr(input string tag, input logic [2:0] exp);
      chk(tag, {29'b0, dut.rr_ptr}, {29'b0, exp});
   endtask

   initial begin
      compared       = 0;
      mismatched     = 0;
      reset          = 1'b1;
      pc_in          = 32'h0;
      is_req_pc      = 1'b0;
      req_pc         = 32'h0;
      predict_target = 32'h0;
      req_taken      = 1'b0;
      flush          = 1'b0;
      step();
      step();
      // Outputs during reset
      lookup("in_reset", 32'h100, 1'b0, 1'b0, 32'h100);
      reset = 1'b0;
      step();

      // Basic allocate and predict
      lookup("rst", 32'h100, 1'b0, 1'b0, 32'h100);
      chk_rr("rst.rr", 3'd0);
      upd(32'h100, 32'h200, 1'b1);
      lookup("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

      // Counter down: 2 -> 1 -> 0 -> 0
      upd(32'h100, 32'h999, 1'b0);
      lookup("nt1", 32'h100, 1'b1, 1'b0, 32'h100);
      upd(32'h100, 32'h999, 1'b0);
      upd(32'h100, 32'h999, 1'b0);
      lookup("nt3", 32'h100, 1'b1, 1'b0, 32'h100);
      // Up: 0 -> 1 (still not taken, proves no wrap at 0)
      upd(32'h100, 32'h300, 1'b1);
      lookup("t1", 32'h100, 1'b1, 1'b0, 32'h100);
      upd(32'h100, 32'h300, 1'b1);
      lookup("t2", 32'h100, 1'b1, 1'b1, 32'h300);
      upd(32'h100, 32'h300, 1'b1);
      upd(32'h100, 32'h300, 1'b1);
      lookup("t4", 32'h100, 1'b1, 1'b1, 32'h300);
      // Saturated at 3: one not-taken -> 2 (taken), another -> 1 (not taken)
      upd(32'h100, 32'h0, 1'b0);
      lookup("sat_nt1", 32'h100, 1'b1, 1'b1, 32'h300);
      upd(32'h100, 32'h0, 1'b0);
      lookup("sat_nt2", 32'h100, 1'b1, 1'b0, 32'h100);

      // Replacement order
      do_reset();
      for (int i = 1; i <= 8; i++) upd(32'h10 * i, 32'h1000 + i, 1'b1);
      chk_rr("fill.rr", 3'd0);
      lookup("fill.first", 32'h10, 1'b1, 1'b1, 32'h1001);
      lookup("fill.last", 32'h80, 1'b1, 1'b1, 32'h1008);
      upd(32'h90, 32'h1009, 1'b1);
      lookup("evict0.old", 32'h10, 1'b0, 1'b0, 32'h10);
      lookup("evict0.new", 32'h90, 1'b1, 1'b1, 32'h1009);
      chk_rr("evict0.rr", 3'd1);
      upd(32'hA0, 32'h100A, 1'b1);
      lookup("evict1.old", 32'h20, 1'b0, 1'b0, 32'h20);
      lookup("evict1.keep", 32'h30, 1'b1, 1'b1, 32'h1003);
      chk_rr("evict1.rr", 3'd2);
      for (int i = 11; i <= 18; i++) upd(32'h10 * i, 32'h1000 + i, 1'b1);
      chk_rr("wrap.rr", 3'd2);
      lookup("wrap.gone", 32'hA0, 1'b0, 1'b0, 32'hA0);
      lookup("wrap.first", 32'hB0, 1'b1, 1'b1, 32'h100B);
      lookup("wrap.last", 32'h120, 1'b1, 1'b1, 32'h1012);

      // Not-taken miss allocates nothing
      do_reset();
      upd(32'h500, 32'h600, 1'b0);
      lookup("ntmiss", 32'h500, 1'b0, 1'b0, 32'h500);
      chk_rr("ntmiss.rr", 3'd0);
      chk("ntmiss.v0", {31'b0, dut.valid[0]}, 32'h0);

      // Flush beats a same-cycle taken update
      do_reset();
      upd(32'h1000, 32'hA000, 1'b1);
      upd(32'h2000, 32'hB000, 1'b1);
      upd(32'h3000, 32'hC000, 1'b1);
      flush = 1'b1;
      upd(32'h700, 32'h7700, 1'b1);
      flush = 1'b0;
      lookup("flush.a", 32'h1000, 1'b0, 1'b0, 32'h1000);
      lookup("flush.c", 32'h3000, 1'b0, 1'b0, 32'h3000);
      lookup("flush.drop", 32'h700, 1'b0, 1'b0, 32'h700);
      chk_rr("flush.rr", 3'd0);
      chk("flush.tag_kept", dut.tag[1], 32'h2000);
      upd(32'h800, 32'h8800, 1'b1);
      lookup("post_flush", 32'h800, 1'b1, 1'b1, 32'h8800);
      chk("post_flush.e0", dut.tag[0], 32'h800);

      // Same-cycle lookup and update: no bypass
      do_reset();
      upd(32'h100, 32'h200, 1'b1);
      is_req_pc      = 1'b1;
      req_pc         = 32'h100;
      predict_target = 32'h900;
      req_taken      = 1'b1;
      lookup("same.old", 32'h100, 1'b1, 1'b1, 32'h200);
      step();
      is_req_pc = 1'b0;
      lookup("same.new", 32'h100, 1'b1, 1'b1, 32'h900);

      // Reset mid-sequence, also beating a concurrent update
      reset     = 1'b1;
      is_req_pc = 1'b1;
      req_pc    = 32'h4000;
      req_taken = 1'b1;
      step();
      reset     = 1'b0;
      is_req_pc = 1'b0;
      lookup("midrst.a", 32'h100, 1'b0, 1'b0, 32'h100);
      lookup("midrst.b", 32'h4000, 1'b0, 1'b0, 32'h4000);
      chk_rr("midrst.rr", 3'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
